// File: rtl/rv32i_types.sv
// Shared RV32I types plus the L1 memory arbiter FSM and requester encodings.
package rv32i_types;

  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] rv32i_line;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } arb_req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared only by rst.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the L1 icache and dcache.
// The granted request is latched into the mem_* registers and held until mem_resp; one
// RELEASE cycle follows each response so stale requests held by the caches are ignored.
module l1_mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic              icache_resp,
  output logic [LINE_W-1:0] icache_rdata,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic              dcache_resp,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  icache_grants,
  output logic [CNT_W-1:0]  dcache_grants
);

  arb_state_t        state_q, state_d;
  arb_req_t          rr_last_q, rr_last_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_req, d_req;
  logic              grant_i, grant_d;
  logic              inc_i, inc_d;

  // Request decode and round-robin tie break against the last granted requester.
  always_comb begin
    i_req   = icache_read;
    d_req   = dcache_read | dcache_write;
    grant_i = i_req & (~d_req | (rr_last_q == DCACHE));
    grant_d = d_req & (~i_req | (rr_last_q == ICACHE));
  end

  // Next-state, downstream request latching and grant-counter increments.
  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    inc_i         = 1'b0;
    inc_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = icache_address;
          rr_last_d     = ICACHE;
          inc_i         = 1'b1;
          state_d       = SERVE_I;
        end else if (grant_d) begin
          // Simultaneous read and write is illegal; the write takes priority.
          mem_read_d    = ~dcache_write;
          mem_write_d   = dcache_write;
          mem_address_d = dcache_address;
          mem_wdata_d   = dcache_wdata;
          rr_last_d     = DCACHE;
          inc_d         = 1'b1;
          state_d       = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered downstream request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_last_q     <= DCACHE;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_last_q     <= rr_last_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Responses are routed only to the requester currently being served.
  always_comb begin
    icache_resp  = (state_q == SERVE_I) & mem_resp;
    dcache_resp  = (state_q == SERVE_D) & mem_resp;
    icache_rdata = mem_rdata;
    dcache_rdata = mem_rdata;
    mem_read     = mem_read_q;
    mem_write    = mem_write_q;
    mem_address  = mem_address_q;
    mem_wdata    = mem_wdata_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_icache_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_i),
    .count (icache_grants)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_dcache_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_d),
    .count (dcache_grants)
  );

endmodule
